// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF response collector.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FINAL
  } coll_state_t;

  localparam int PUF_COUNT_BITS = 16;

  typedef logic [PUF_COUNT_BITS-1:0] count_t;

  function automatic int vote_width(input int reps);
    return (reps < 1) ? 1 : $clog2(reps + 1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises the selected oscillator, detects rising edges and
// counts them into a saturating counter with clear and enable.
module ro_edge_counter #(
  parameter int COUNT_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ro,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [COUNT_BITS-1:0] o_count
);

  logic [1:0]            r_sync;
  logic                  r_prev;
  logic [COUNT_BITS-1:0] r_count;
  logic                  w_rise;

  assign w_rise  = r_sync[1] & ~r_prev;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[0], i_ro};
      r_prev <= r_sync[1];
      // clear wins over a coincident edge
      if (i_clr) begin
        r_count <= '0;
      end else if (i_en && w_rise && (r_count != '1)) begin
        r_count <= r_count + COUNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/ro_response_collector.sv
// RO-PUF response collector: slot bank, pairwise compare, voting, FSM.
// Majority voting across rounds is built when PUF_MAJORITY_VOTE_EN is defined.
module ro_response_collector
  import puf_pkg::*;
#(
  parameter  int NUM_LOOPS   = 4,
  parameter  int REPETITIONS = 2,
  parameter  int COUNT_BITS  = 16,
  localparam int RESP_BITS   = NUM_LOOPS / 2,
  localparam int SEL_BITS    = $clog2(NUM_LOOPS - 1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ro_in,
  input  logic                 reset_puf,
  input  logic                 enable_puf,
  input  logic [SEL_BITS-1:0]  select_puf,
  input  logic                 store_response_puf,
  input  logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 response_valid
);

  localparam int IDX_BITS = (NUM_LOOPS > 2) ? $clog2(NUM_LOOPS) : 1;
  localparam int VW       = vote_width(REPETITIONS);

  logic [COUNT_BITS-1:0] w_count;
  logic [COUNT_BITS-1:0] r_slot [NUM_LOOPS];
  logic [IDX_BITS-1:0]   w_idx;
  logic                  w_store_ok;
  logic                  w_store_last;
  logic                  r_cmp_pending;
  logic [RESP_BITS-1:0]  w_bits;
  logic [RESP_BITS-1:0]  w_final;
  logic [RESP_BITS-1:0]  r_response;
  logic [VW-1:0]         r_rounds;
  logic [VW-1:0]         w_rounds_nx;
  logic                  r_done_q;
  logic                  r_done_q2;
  logic                  w_done_rise;
  logic                  w_finalize;
  coll_state_t           r_state;
  coll_state_t           w_state_nx;

  ro_edge_counter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_cnt (
    .i_clk  (clk),
    .i_reset(reset),
    .i_ro   (ro_in),
    .i_clr  (reset_puf),
    .i_en   (enable_puf),
    .o_count(w_count)
  );

  assign w_idx        = select_puf[IDX_BITS-1:0];
  assign w_store_ok   = store_response_puf &&
                        (32'(select_puf) < 32'(NUM_LOOPS));
  assign w_store_last = w_store_ok &&
                        (w_idx == IDX_BITS'(NUM_LOOPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) r_slot[i] <= '0;
      r_cmp_pending <= 1'b0;
    end else begin
      if (w_store_ok) r_slot[w_idx] <= w_count;
      r_cmp_pending <= w_store_last;
    end
  end

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < RESP_BITS; i++) begin
      w_bits[i] = r_slot[2*i] > r_slot[2*i+1];
    end
  end

  // A compare coinciding with finalize is folded into this response
  assign w_rounds_nx = r_rounds +
    VW'(r_cmp_pending && (r_rounds != '1));

`ifdef PUF_MAJORITY_VOTE_EN
  logic [VW-1:0] r_votes    [RESP_BITS];
  logic [VW-1:0] w_votes_nx [RESP_BITS];

  always_comb begin
    w_final = '0;
    for (int i = 0; i < RESP_BITS; i++) begin
      w_votes_nx[i] = r_votes[i];
      if (r_cmp_pending && w_bits[i] && (r_votes[i] != '1)) begin
        w_votes_nx[i] = r_votes[i] + VW'(1);
      end
      w_final[i] = w_votes_nx[i] > VW'(REPETITIONS / 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_finalize) begin
      for (int i = 0; i < RESP_BITS; i++) r_votes[i] <= '0;
    end else begin
      for (int i = 0; i < RESP_BITS; i++) r_votes[i] <= w_votes_nx[i];
    end
  end
`else
  logic [RESP_BITS-1:0] r_last_bits;

  assign w_final = r_cmp_pending ? w_bits : r_last_bits;

  always_ff @(posedge clk) begin
    if (reset || w_finalize) begin
      r_last_bits <= '0;
    end else if (r_cmp_pending) begin
      r_last_bits <= w_bits;
    end
  end
`endif

  assign w_done_rise = r_done_q & ~r_done_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_q   <= 1'b0;
      r_done_q2  <= 1'b0;
      r_state    <= IDLE;
      r_rounds   <= '0;
      r_response <= '0;
    end else begin
      r_done_q  <= done;
      r_done_q2 <= r_done_q;
      r_state   <= w_state_nx;
      if (w_finalize) begin
        r_rounds   <= '0;
        r_response <= (w_rounds_nx == '0) ? '0 : w_final;
      end else begin
        r_rounds <= w_rounds_nx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_finalize = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_done_rise) w_state_nx = WAIT;
      end
      WAIT: begin
        w_finalize = 1'b1;
        w_state_nx = FINAL;
      end
      FINAL: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign response       = r_response;
  assign response_valid = (r_state == FINAL);

endmodule
